// File: rtl/adder_pkg.sv
// Shared types for the adder family: state encoding of the bit-serial subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell, used as the bit-slice of the serial datapaths.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first over WIDTH cycles,
// computed as a + ~b + 1 through a single fulladder slice.
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  sub_state_t       state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             a_msb, b_msb;
  logic             accept, last_bit;
  logic             b_inv, bit_sum, bit_carry;

  assign b_inv = ~b_sh[0];

  fulladder u_bit (
    .a     (a_sh[0]),
    .b     (b_inv),
    .c_in  (carry),
    .sum   (bit_sum),
    .c_out (bit_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      cnt      <= '0;
      carry    <= 1'b1;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      carry <= 1'b1;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= {bit_sum, diff_sh[WIDTH-1:1]};
      carry   <= bit_carry;
      if (last_bit) begin
        // The final sum bit is the result MSB, so the flags are resolved on this edge.
        borrow   <= ~bit_carry;
        overflow <= (a_msb != b_msb) && (bit_sum != a_msb);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign diff = diff_sh;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` over `WIDTH` cycles, LSB first. It reuses the existing `fulladder` cell with `b` inverted and an initial carry of 1. It is the sequential counterpart to the combinational adder cells: operands come in on a valid/ready handshake, and the result leaves on a second valid/ready handshake. It sits wherever area matters more than latency.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range is ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operands `a`/`b` are valid
- `in_ready`  out  1  block can accept operands
- `a`  in  WIDTH  minuend
- `b`  in  WIDTH  subtrahend
- `out_valid`  out  1  result is valid
- `out_ready`  in  1  consumer accepts the result
- `diff`  out  WIDTH  `a - b` mod 2^WIDTH
- `borrow`  out  1  unsigned borrow, asserted when `a < b`
- `overflow`  out  1  signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` is 1; it is a combinational decode of `state == IDLE`.
  - On `in_valid && in_ready`, capture `a` into `a_sh` and `b` into `b_sh`.
  - Record `a[WIDTH-1]` and `b[WIDTH-1]`.
  - Set `carry` to 1, clear `cnt`, and go to RUN.
- RUN, once per cycle:
  - Compute `fulladder(a_sh[0], ~b_sh[0], carry)`.
  - Shift the sum into `diff_sh` from the MSB side.
  - Shift `a_sh` and `b_sh` right by 1.
  - Set `carry <= c_out` and increment `cnt`.
  - After the `WIDTH`-th bit (`cnt == WIDTH-1`), go to DONE.
- DONE:
  - `out_valid` is 1.
  - `diff`, `borrow` and `overflow` are held stable until `out_valid && out_ready`, then the FSM returns to IDLE.
- Result rules:
  - `borrow = ~carry_final`.
  - `overflow = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb)`.
- `in_valid` is ignored outside IDLE.
- `a`/`b` only need to be stable during the handshake cycle.
- `out_ready` is ignored outside DONE.
- Outputs `diff`, `borrow` and `overflow` show register contents at all times. They are meaningful only while `out_valid` is 1.

## Timing
- Reset (asynchronous, active-high):
  - The FSM goes to IDLE.
  - `a_sh`, `b_sh`, `diff_sh`, `cnt`, `borrow` and `overflow` clear to 0; `carry` clears to 1.
  - `out_valid` is 0.
  - `in_ready` is 1 (it decodes IDLE). No handshake is taken while `rst` is high.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No `out_valid` pulse follows.
- Cycle timing, with the input handshake sampled at edge T:
  - RUN occupies edges T+1 … T+WIDTH.
  - `out_valid` rises after edge T+WIDTH, so latency is WIDTH cycles from accept to `out_valid`.
- With `out_ready` held at 1, DONE lasts 1 cycle.
- The next accept is possible at edge T+WIDTH+2, giving a minimum initiation interval of WIDTH+2 cycles.
- `out_ready` held low keeps the FSM in DONE indefinitely, with outputs unchanged.
- `in_ready` is 0 in RUN and DONE. There is no overlap of input accept and output hand-off.
- `cnt` width is `$clog2(WIDTH)`. It never wraps during RUN because the exit is at `WIDTH-1`.

## Structure
- Shared package `adder_pkg` holds the `sub_state_t` enum (IDLE, RUN, DONE).
- One sub-module: the existing `fulladder` (ports `a`, `b`, `c_in`, `sum`, `c_out`), instantiated once as the bit-slice.
- All other logic is local flops plus the FSM.

## Test plan
All scenarios use WIDTH=8.
- Basic: a=0x05, b=0x03 → diff=0x02, borrow=0, overflow=0; `out_valid` rises 8 cycles after accept.
- Unsigned borrow: a=0x03, b=0x05 → diff=0xFE, borrow=1, overflow=0.
- Signed overflow: a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1. Also a=0x7F, b=0xFF → diff=0x80, borrow=1, overflow=1.
- Zero/identity: a=0x00, b=0x00 → diff=0x00, borrow=0. Also a=0xA5, b=0xA5 → diff=0x00, borrow=0, overflow=0.
- Backpressure and handshake:
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_valid` stays 1 and `diff` is stable.
  - Pulse `in_valid` with new operands during RUN/DONE → ignored, and the first result is unchanged.
  - With `out_ready`=1 throughout, back-to-back requests are accepted exactly every 10 cycles.
- Reset mid-operation: assert `rst` at RUN bit 4 → `out_valid`=0, `in_ready`=1 immediately. After release, a=0x10, b=0x01 → diff=0x0F.
